// File: rtl/deser_pkg.sv
// Shared constants and helpers for the multi-channel serial deserializer.
package deser_pkg;

  localparam int          DROP_CNT_W   = 16;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deser_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above rr,
// with wrap-around; rr moves past the winner on advance.
module deser_rr_arb
  import deser_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic              ti_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [CH_W-1:0]   grant,
  output logic              grant_v
);

  logic [CH_W-1:0] rr;

  // Walk downward so the lowest offset from rr wins last.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx     = '0;
    grant   = '0;
    grant_v = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr) + i) % NUM_CH);
      if (req[idx]) begin
        grant   = idx;
        grant_v = 1'b1;
      end
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      rr <= '0;
    end else if (advance && grant_v) begin
      if (int'(grant) == NUM_CH - 1)
        rr <= '0;
      else
        rr <= grant + 1'b1;
    end
  end

endmodule

// File: rtl/serial_deser_mc.sv
// NUM_CH-channel MSB-first deserializer with round-robin output drain.
// Optional per-channel drop counters: define DESER_DROP_CNT_EN.
module serial_deser_mc
  import deser_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic                  ti_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  resync,
  input  logic [NUM_CH-1:0]     serial_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic [NUM_CH-1:0]     ovf,
  input  logic [CH_W-1:0]       cnt_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int BC_W = $clog2(WORD_W);

  logic [BC_W-1:0]   bcnt;
  logic [WORD_W-2:0] sr [NUM_CH];
  logic [WORD_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] hold_v;
  logic [WORD_W-1:0] new_word [NUM_CH];

  logic              sample;
  logic              done;
  logic              xfer;
  logic [CH_W-1:0]   grant;
  logic              grant_v;
  logic [NUM_CH-1:0] freed;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drop;

  assign sample = enable & ~resync;
  assign done   = sample & (bcnt == BC_W'(WORD_W - 1));
  assign xfer   = grant_v & (~out_valid | out_ready);

  // A hold slot drained this cycle can accept the new word.
  always_comb begin
    freed = '0;
    load  = '0;
    drop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      new_word[c] = {sr[c], serial_in[c]};
      freed[c] = xfer && (grant == CH_W'(c));
      load[c]  = done && (!hold_v[c] || freed[c]);
      drop[c]  = done && hold_v[c] && !freed[c];
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset || resync)
      bcnt <= '0;
    else if (enable)
      bcnt <= done ? '0 : bcnt + 1'b1;
  end

  always_ff @(posedge ti_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset || resync)
        sr[c] <= '0;
      else if (enable)
        sr[c] <= new_word[c][WORD_W-2:0];
    end
  end

  always_ff @(posedge ti_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        hold[c]   <= '0;
        hold_v[c] <= 1'b0;
      end else if (load[c]) begin
        hold[c]   <= new_word[c];
        hold_v[c] <= 1'b1;
      end else if (freed[c]) begin
        hold_v[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset)
      ovf <= '0;
    else
      ovf <= ovf | drop;
  end

  deser_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .ti_clk  (ti_clk),
    .reset   (reset),
    .req     (hold_v),
    .advance (xfer),
    .grant   (grant),
    .grant_v (grant_v)
  );

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= hold[grant];
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] dcnt [NUM_CH];

  always_ff @(posedge ti_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset)
        dcnt[c] <= '0;
      else if (drop[c] && dcnt[c] != DROP_CNT_MAX)
        dcnt[c] <= dcnt[c] + 1'b1;
    end
  end

  always_comb begin
    drop_cnt = '0;
    if (int'(cnt_sel) < NUM_CH)
      drop_cnt = dcnt[cnt_sel];
  end
`else
  logic cnt_sel_unused;
  assign cnt_sel_unused = ^cnt_sel;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_deser_mc.sv
// Self-checking bench for serial_deser_mc (WORD_W=16, NUM_CH=4).
module tb_serial_deser_mc;

`ifdef DESER_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        ti_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        resync;
  logic [3:0]  serial_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic [3:0]  ovf;
  logic [1:0]  cnt_sel;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 ti_clk = ~ti_clk;

  serial_deser_mc #(
    .WORD_W (16),
    .NUM_CH (4)
  ) dut (
    .ti_clk    (ti_clk),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .serial_in (serial_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .ovf       (ovf),
    .cnt_sel   (cnt_sel),
    .drop_cnt  (drop_cnt)
  );

  // Scoreboard: every accepted word must be the next expected word.
  always @(negedge ti_clk) begin
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_extra: got ch %0d data %h, required no word",
                 out_ch, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_ch !== mon_e.ch || out_data !== mon_e.data) begin
          errors++;
          $display("FAIL mon_word: got ch %0d data %h, required ch %0d data %h",
                   out_ch, out_data, mon_e.ch, mon_e.data);
        end
      end
    end
  end

  task automatic tick(input logic en, input logic rs,
                      input logic [3:0] sin, input logic rdy);
    enable    = en;
    resync    = rs;
    serial_in = sin;
    out_ready = rdy;
    @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(0, 0, 4'h0, 0);
    tick(0, 0, 4'h0, 0);
    reset = 1'b0;
  endtask

  // Sends one word per channel MSB-first and queues the expected output.
  task automatic send_words(input logic [15:0] w [4], input int gap_mode);
    logic [3:0] s;
    exp_t       e;
    int         g;
    for (int b = 15; b >= 0; b--) begin
      for (int c = 0; c < 4; c++) s[c] = w[c][b];
      tick(1, 0, s, 1);
      g = 0;
      if (b > 0) begin
        if (gap_mode == 1 && b % 4 == 0) g = 3;
        else if (gap_mode == 2) g = $urandom_range(0, 2);
      end
      repeat (g) tick(0, 0, 4'($urandom), 1);
    end
    for (int c = 0; c < 4; c++) begin
      e.ch   = 2'(c);
      e.data = w[c];
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 40) begin
      tick(0, 0, 4'h0, 1);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, required 0",
               exp_q.size());
    end
    repeat (3) tick(0, 0, 4'h0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0) begin
      errors++; $display("FAIL rst_data: got %h, required 0000", out_data);
    end
    checks++;
    if (out_ch !== 2'd0) begin
      errors++; $display("FAIL rst_ch: got %0d, required 0", out_ch);
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++; $display("FAIL rst_ovf: got %b, required 0000", ovf);
    end
    checks++;
    if (drop_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_dropcnt: got %h, required 0000", drop_cnt);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w [4];
    logic [3:0]  s;
    w = '{16'hA5C3, 16'hFFFF, 16'h0001, 16'h8000};
    do_reset();
    for (int b = 15; b >= 0; b--) begin
      for (int c = 0; c < 4; c++) s[c] = w[c][b];
      tick(1, 0, s, 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: out_valid %b, required 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 4'h0, 1);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k) || out_data !== w[k]) begin
        errors++;
        $display("FAIL basic_word%0d: got v %b ch %0d data %h, required v 1 ch %0d data %h",
                 k, out_valid, out_ch, out_data, k, w[k]);
      end
    end
    tick(0, 0, 4'h0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_end: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  ech [5];
    logic [15:0] ed  [5];
    ech = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ed  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    do_reset();
    cnt_sel = 2'd2;
    for (int n = 1; n <= 48; n++) begin
      tick(1, 0, 4'b0101, 0);
      if (n >= 17 && n % 8 == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'hFFFF) begin
          errors++;
          $display("FAIL bp_hold@%0d: got v %b ch %0d data %h, required v 1 ch 0 data ffff",
                   n, out_valid, out_ch, out_data);
        end
      end
      if (n == 40) begin
        checks++;
        if (ovf !== 4'b1110) begin
          errors++; $display("FAIL bp_ovf2: got %b, required 1110", ovf);
        end
        checks++;
        if (drop_cnt !== (DC_EN ? 16'd1 : 16'd0)) begin
          errors++;
          $display("FAIL bp_dropcnt: got %0d, required %0d", drop_cnt, DC_EN ? 1 : 0);
        end
      end
    end
    checks++;
    if (ovf !== 4'b1111) begin
      errors++; $display("FAIL bp_ovf3: got %b, required 1111", ovf);
    end
    cnt_sel = 2'd0;
    #1;
    checks++;
    if (drop_cnt !== (DC_EN ? 16'd1 : 16'd0)) begin
      errors++;
      $display("FAIL bp_dropcnt0: got %0d, required %0d", drop_cnt, DC_EN ? 1 : 0);
    end
    cnt_sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ch !== ech[k] || out_data !== ed[k]) begin
        errors++;
        $display("FAIL bp_rel%0d: got v %b ch %0d data %h, required v 1 ch %0d data %h",
                 k, out_valid, out_ch, out_data, ech[k], ed[k]);
      end
      tick(0, 0, 4'h0, 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count: extra word valid, required 5 words only");
    end
  endtask

  task automatic test_simul_xfer();
    logic [15:0] w1 [4];
    logic [15:0] w2 [4];
    logic [3:0]  s;
    logic        rdy;
    int          b;
    for (int c = 0; c < 4; c++) begin
      w1[c] = 16'($urandom);
      w2[c] = 16'($urandom);
    end
    do_reset();
    for (int n = 1; n <= 32; n++) begin
      b = 15 - ((n - 1) % 16);
      for (int c = 0; c < 4; c++) s[c] = (n <= 16) ? w1[c][b] : w2[c][b];
      rdy = (n >= 17 && n <= 19) || n == 32;
      tick(1, 0, s, rdy);
      if (n == 31) begin
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== w1[2]) begin
          errors++;
          $display("FAIL sim_hold: got v %b ch %0d data %h, required v 1 ch 2 data %h",
                   out_valid, out_ch, out_data, w1[2]);
        end
      end
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++; $display("FAIL sim_ovf: got %b, required 0000", ovf);
    end
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== w1[3]) begin
      errors++;
      $display("FAIL sim_ch3: got v %b ch %0d data %h, required v 1 ch 3 data %h",
               out_valid, out_ch, out_data, w1[3]);
    end
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 4'h0, 1);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k) || out_data !== w2[k]) begin
        errors++;
        $display("FAIL sim_next%0d: got v %b ch %0d data %h, required v 1 ch %0d data %h",
                 k, out_valid, out_ch, out_data, k, w2[k]);
      end
    end
    tick(0, 0, 4'h0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sim_end: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_resync();
    logic [15:0] w [4];
    do_reset();
    exp_q.delete();
    mon_en = 1'b1;
    repeat (7) tick(1, 0, 4'($urandom), 1);
    tick(1, 1, 4'($urandom), 1);
    w[0] = 16'h1234;
    for (int c = 1; c < 4; c++) w[c] = 16'($urandom);
    send_words(w, 0);
    drain();
  endtask

  task automatic test_enable_gaps();
    logic [15:0] w [4];
    w[0] = 16'hBEEF;
    for (int c = 1; c < 4; c++) w[c] = 16'($urandom);
    send_words(w, 1);
    drain();
  endtask

  task automatic test_random();
    logic [15:0] w [4];
    repeat (10) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 15)) tick(1, 0, 4'($urandom), 1);
        tick(1'($urandom_range(0, 1)), 1, 4'($urandom), 1);
      end
      for (int c = 0; c < 4; c++) w[c] = 16'($urandom);
      send_words(w, 2);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w [4];
    mon_en = 1'b0;
    do_reset();
    repeat (37) tick(1, 0, 4'($urandom), 0);
    checks++;
    if (ovf !== 4'b1110) begin
      errors++; $display("FAIL rm_pre_ovf: got %b, required 1110", ovf);
    end
    reset = 1'b1;
    tick(0, 0, 4'h0, 0);
    checks++;
    if (out_valid !== 1'b0 || ovf !== 4'b0000 || drop_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rm_cleared: got v %b ovf %b dc %h, required v 0 ovf 0000 dc 0000",
               out_valid, ovf, drop_cnt);
    end
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) w[c] = 16'($urandom);
    send_words(w, 0);
    drain();
    mon_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    resync    = 1'b0;
    serial_in = 4'h0;
    out_ready = 1'b0;
    cnt_sel   = 2'd2;
    test_reset();
    test_basic();
    test_backpressure();
    test_simul_xfer();
    test_resync();
    test_enable_gaps();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
